mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Sequences the CPU's single shared memory bus between the instruction-fetch port (IF, read-only) and the data port (MEM stage, read/write).
- Grants one transaction at a time and holds each granted transaction until the bus acknowledges or times out.
- Returns read data and a one-cycle ready pulse to the granted port, and generates per-port stall requests for the pipeline controller.
- Sits between the core pipeline and the memory/peripheral bus inside the top-level CPU.

Parameters:
ADDR_W, 32, address width of both ports and the bus
DATA_W, 32, data width of both ports and the bus
TIMEOUT, 255, max cycles waiting for bus_ack before an aborted transaction; legal range 1..255

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low
if_req  input  1  IF read request, held until if_ready
if_addr  input  ADDR_W  IF read address
if_rdata  output  DATA_W  IF read data, valid when if_ready=1
if_ready  output  1  one-cycle completion pulse for IF
mem_req  input  1  data-port request, held until mem_ready
mem_we  input  1  1=write, 0=read
mem_sel  input  4  byte enables
mem_addr  input  ADDR_W  data-port address
mem_wdata  input  DATA_W  data-port write data
mem_rdata  output  DATA_W  data-port read data, valid when mem_ready=1
mem_ready  output  1  one-cycle completion pulse for data port
bus_req  output  1  bus transaction strobe, held until ack/timeout
bus_we  output  1  bus write enable
bus_sel  output  4  bus byte enables (4'b1111 for IF)
bus_addr  output  ADDR_W  bus address
bus_wdata  output  DATA_W  bus write data
bus_rdata  input  DATA_W  bus read data, sampled with bus_ack
bus_ack  input  1  bus completion, may assert in the first cycle of bus_req
stall_if  output  1  if_req & ~if_ready (combinational)
stall_mem  output  1  mem_req & ~mem_ready (combinational)
bus_err  output  1  one-cycle pulse, coincident with ready, on timeout abort

Behaviour:
- Reset is synchronous: when rst=0 at a clock edge, the following are cleared to 0 and the state goes to IDLE:
  - bus_req, bus_we, bus_sel, bus_addr, bus_wdata
  - if_ready, mem_ready, if_rdata, mem_rdata, bus_err
  - the timeout counter
- Reset mid-transaction drops bus_req at that edge. Any bus_ack arriving after reset is ignored.
- FSM states:
  - IDLE: on a rising edge with mem_req=1, latch mem_we/sel/addr/wdata onto the bus registers, set bus_req=1, and go to BUS_MEM. Else, if if_req=1, latch if_addr with we=0 and sel=4'b1111, set bus_req=1, and go to BUS_IF. Else stay in IDLE.
  - BUS_MEM / BUS_IF: bus outputs stay stable and the counter increments each cycle. On bus_ack=1:
    - capture bus_rdata into the owner's rdata (mem_rdata for MEM, for both read and write; if_rdata for IF);
    - set that port's ready=1 and bus_req=0;
    - go to RESP.
  - Timeout abort in BUS_MEM / BUS_IF: if bus_ack=0 and counter==TIMEOUT-1, do the same as ack, but rdata<=0 and bus_err=1.
  - RESP: ready and bus_err clear to 0, counter clears to 0, go to IDLE. This gives the requester one edge to drop or change its request.
- Arbitration:
  - Fixed priority, MEM over IF, evaluated only in IDLE.
  - No preemption: a granted transaction always completes.
  - Simultaneous mem_req and if_req in IDLE: MEM is granted, IF waits and is granted on the next IDLE.
- Latency:
  - Request sampled in IDLE at edge t; bus_req is high from t+1.
  - If ack is seen at edge t+1+k, ready is high in the cycle after it.
  - Zero-wait ack (k=0) gives 3 cycles from request to ready; back-to-back transactions are spaced 3 cycles minimum.
- rdata holds its value after the ready pulse until the next completion for that port.
- bus_ack in IDLE or RESP is spurious and ignored: no state change.
- A request dropped before it is granted is simply never served. A request dropped after it is granted still completes on the bus, and the ready pulse is still issued.

Test Plan:
- Reset: hold rst=0 for 3 cycles with both reqs high -> all outputs 0, bus_req stays 0 until the cycle after rst=1.
- IF read, zero-wait: if_req=1, if_addr=0x00000010, bus_ack=1 with bus_rdata=0x3C010001 in the first bus_req cycle -> bus_addr=0x10, bus_sel=4'hF, bus_we=0; if_ready pulses one cycle with if_rdata=0x3C010001; stall_if=1 until that cycle.
- Collision: mem_req (write, addr 0x100, wdata 0xDEADBEEF, sel 4'b0011) and if_req raised in the same cycle, ack 2 cycles after each bus_req -> MEM write appears first on the bus, then the IF read; mem_ready precedes if_ready; stall_if stays high throughout.
- Timeout: TIMEOUT=4, mem_req read with bus_ack never asserted -> bus_req high exactly 4 cycles, then mem_ready=1, bus_err=1, mem_rdata=0; the next pending if_req is granted normally.
- Reset mid-op: assert rst=0 while in BUS_IF, then give bus_ack afterwards -> bus_req=0 after the reset edge, no if_ready pulse, state IDLE.
- Spurious ack: pulse bus_ack in IDLE with no reqs -> no ready, no bus_err, bus_req stays 0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the IF read port and the MEM data port.
// Fixed MEM-over-IF priority, one transaction at a time, completion by ack or timeout.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,

    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [3:0]        mem_sel,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,

    output logic              bus_req,
    output logic              bus_we,
    output logic [3:0]        bus_sel,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,

    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_err
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS_MEM = 2'd1,
        BUS_IF  = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;

    logic                bus_req_nx;
    logic                bus_we_nx;
    logic [3:0]          bus_sel_nx;
    logic [ADDR_W-1:0]   bus_addr_nx;
    logic [DATA_W-1:0]   bus_wdata_nx;
    logic                if_ready_nx;
    logic                mem_ready_nx;
    logic                bus_err_nx;
    logic [DATA_W-1:0]   if_rdata_nx;
    logic [DATA_W-1:0]   mem_rdata_nx;
    logic                done_c;
    logic [DATA_W-1:0]   rdata_c;

    // State and output registers; reset also drops any in-flight bus_req.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_sel   <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            bus_err   <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            bus_req   <= bus_req_nx;
            bus_we    <= bus_we_nx;
            bus_sel   <= bus_sel_nx;
            bus_addr  <= bus_addr_nx;
            bus_wdata <= bus_wdata_nx;
            if_ready  <= if_ready_nx;
            mem_ready <= mem_ready_nx;
            bus_err   <= bus_err_nx;
            if_rdata  <= if_rdata_nx;
            mem_rdata <= mem_rdata_nx;
        end
    end

    // Next-state and next-output logic; ready and bus_err are single-cycle pulses.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        bus_req_nx   = bus_req;
        bus_we_nx    = bus_we;
        bus_sel_nx   = bus_sel;
        bus_addr_nx  = bus_addr;
        bus_wdata_nx = bus_wdata;
        if_ready_nx  = 1'b0;
        mem_ready_nx = 1'b0;
        bus_err_nx   = 1'b0;
        if_rdata_nx  = if_rdata;
        mem_rdata_nx = mem_rdata;
        done_c       = 1'b0;
        rdata_c      = '0;

        case (state)
            IDLE: begin
                if (mem_req) begin
                    bus_req_nx   = 1'b1;
                    bus_we_nx    = mem_we;
                    bus_sel_nx   = mem_sel;
                    bus_addr_nx  = mem_addr;
                    bus_wdata_nx = mem_wdata;
                    state_nx     = BUS_MEM;
                end else if (if_req) begin
                    bus_req_nx   = 1'b1;
                    bus_we_nx    = 1'b0;
                    bus_sel_nx   = 4'b1111;
                    bus_addr_nx  = if_addr;
                    bus_wdata_nx = '0;
                    state_nx     = BUS_IF;
                end
            end

            BUS_MEM, BUS_IF: begin
                cnt_nx = cnt + CNT_W'(1);
                // An ack wins over a timeout that lands on the same cycle.
                done_c  = bus_ack || (cnt == CNT_LAST);
                rdata_c = bus_ack ? bus_rdata : '0;
                if (done_c) begin
                    bus_req_nx = 1'b0;
                    bus_err_nx = !bus_ack;
                    state_nx   = RESP;
                    if (state == BUS_MEM) begin
                        mem_ready_nx = 1'b1;
                        mem_rdata_nx = rdata_c;
                    end else begin
                        if_ready_nx = 1'b1;
                        if_rdata_nx = rdata_c;
                    end
                end
            end

            RESP: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end

            default: state_nx = IDLE;
        endcase
    end

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = mem_req & ~mem_ready;

endmodule
